next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Parametrised fetch-address generator replacing the combinational next-address mux in the pipeline IF stage. Owns the program-counter register, predicts conditional branches at fetch with a table of 2-bit saturating counters, and resolves branches and jumps arriving from EX. On a mispredict or jump it redirects the PC and raises a flush for IF/ID.

## Interface
- XLEN, 32, address/data width
- BHT_DEPTH, 64, number of prediction counters; power of two, at least 2
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- stall  in  1  hazard-unit hold of the fetch PC
- pc  out  XLEN  current fetch address (registered)
- if_br  in  1  instruction at `pc` is a conditional branch (pre-decoded in IF)
- if_offset  in  XLEN  sign-extended B-type offset of that instruction
- pred_taken  out  1  fetch-time prediction for `pc`; carried down the pipeline by ID/EX registers
- ex_valid  in  1  EX holds a real instruction (0 for a bubble)
- ex_pc_src  in  3  000 seq, 001 blt, 010 bge, 011 beq, 100 bne, 101 jal, 110 jalr, 111 reserved (treated as 000)
- ex_pc  in  XLEN  PC of the EX instruction
- ex_offset_addr  in  XLEN  branch/jal target
- ex_result  in  XLEN  ALU result, used as the jalr target
- ex_zero, ex_less  in  1 each  ALU flags
- ex_pred_taken  in  1  prediction made for the EX instruction
- flush  out  1  redirect this cycle; IF/ID must squash

## Operation
- Actual taken (EX): blt = ex_less, bge = !ex_less, beq = ex_zero, bne = !ex_zero. Evaluated only when ex_valid=1.
- Redirect (flush=1) when ex_valid=1 and one of:
  - conditional branch with actual taken ≠ ex_pred_taken; target = taken ? ex_offset_addr : ex_pc+4
  - jal; target = ex_offset_addr
  - jalr; target = ex_result with bit 0 cleared
- Next-PC priority: rst → RESET_PC; flush → redirect target; stall → pc; pred_taken → pc+if_offset; else pc+4.
- flush overrides stall.
- pred_taken = if_br & bht[idx(pc)][1], where idx(a) = a[log2(BHT_DEPTH)+1:2].
- BHT update: when ex_valid=1 and ex_pc_src is 001–100, counter at idx(ex_pc) increments on taken and decrements on not-taken, saturating at 00/11.
  - Updates occur regardless of stall.
- Read and update of the same index in one cycle: the read returns the old value (no bypass).
- All additions wrap modulo 2^XLEN.

## Timing
- Reset: pc=RESET_PC, all counters=01 (weakly not-taken), on the edge where rst=1. rst during a pending redirect discards the redirect.
- pred_taken and flush are combinational from current state and inputs. Neither has a reset value of its own; with rst=1 and ex_valid low, both read 0.
- Redirect latency: 1 edge. pc shows the target on the cycle after flush=1.
- Branch penalty: a mispredict or jump costs 2 fetched instructions. A correctly predicted taken branch costs 0 extra cycles.
- Counter update is visible to fetch on the cycle after the EX edge.

## Configuration
- BRANCH_PREDICT_EN defined: BHT and prediction as above.
- Undefined:
  - no counter storage is instantiated and pred_taken is constant 0
  - next PC is pc+4 unless redirected
  - every taken conditional branch flushes
  - ex_pred_taken is ignored (treated as 0)

## Structure
- Shared package (cpu_pkg):
  - ex_pc_src encoding constants (PCSRC_SEQ … PCSRC_JALR)
  - counter reset constant CNT_WNT = 2'b01
  - instruction-step constant 4
- Sub-module branch_history_table (BHT_DEPTH, read port on idx(pc), write port on idx(ex_pc)) holds counter storage and the saturation logic. It is instantiated only under BRANCH_PREDICT_EN.

## Test plan
- Reset then release: with rst=1 for 2 cycles, pc=0x0, flush=0, pred_taken=0. With no branches, pc then steps 0x0, 0x4, 0x8.
- Stall: stall=1 for 2 cycles at pc=0x8 → pc holds 0x8, then resumes at 0xC.
- beq mispredict: ex_pc_src=011, ex_zero=1, ex_pred_taken=0, ex_offset_addr=0x40, ex_pc=0x10 → flush=1, next pc=0x40, counter[4] goes 01→10.
- Training: branch at 0x10 resolves taken twice (counter=11). Fetch at 0x10 with if_br=1, if_offset=0xFFFF_FFF0 → pred_taken=1, next pc=0x0. Without BRANCH_PREDICT_EN: pred_taken=0, next pc=0x14.
- bne predicted taken but not taken: ex_pc_src=100, ex_zero=1, ex_pred_taken=1, ex_pc=0x20 → flush=1, next pc=0x24, counter decrements.
- jalr with stall: ex_pc_src=110, ex_result=0x101, stall=1 → flush=1, next pc=0x100. Same inputs with ex_valid=0 → no flush, pc held.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch-address generator:
//   - ex_pc_src encodings driven by the EX stage
//   - 2-bit prediction counter reset value and saturating update
//   - instruction step (bytes between sequential fetches)
//   - small decode helpers for conditional branches
// -----------------------------------------------------------------------------
package cpu_pkg;

  // ex_pc_src encodings
  localparam logic [2:0] PCSRC_SEQ  = 3'b000;
  localparam logic [2:0] PCSRC_BLT  = 3'b001;
  localparam logic [2:0] PCSRC_BGE  = 3'b010;
  localparam logic [2:0] PCSRC_BEQ  = 3'b011;
  localparam logic [2:0] PCSRC_BNE  = 3'b100;
  localparam logic [2:0] PCSRC_JAL  = 3'b101;
  localparam logic [2:0] PCSRC_JALR = 3'b110;
  localparam logic [2:0] PCSRC_RSVD = 3'b111;  // behaves exactly like PCSRC_SEQ

  // Counter value after reset: weakly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;

  // Byte distance between consecutive instructions
  localparam int unsigned INSN_STEP = 4;

  // Saturating 2-bit counter update: count up on taken, down on not-taken,
  // sticking at 2'b11 and 2'b00 respectively.
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt,
                                            input logic       taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) begin
        res = cnt + 2'b01;
      end else begin
        res = cnt;
      end
    end else begin
      if (cnt != 2'b00) begin
        res = cnt - 2'b01;
      end else begin
        res = cnt;
      end
    end
    return res;
  endfunction

  // True for the four conditional-branch encodings
  function automatic logic is_cond_branch(input logic [2:0] src);
    logic res;
    case (src)
      PCSRC_BLT, PCSRC_BGE, PCSRC_BEQ, PCSRC_BNE: res = 1'b1;
      default:                                   res = 1'b0;
    endcase
    return res;
  endfunction

  // Actual branch outcome from the ALU flags; 0 for anything that is not a
  // conditional branch.
  function automatic logic branch_outcome(input logic [2:0] src,
                                          input logic       zero,
                                          input logic       less);
    logic res;
    case (src)
      PCSRC_BLT: res = less;
      PCSRC_BGE: res = ~less;
      PCSRC_BEQ: res = zero;
      PCSRC_BNE: res = ~zero;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
// Table of BHT_DEPTH 2-bit saturating prediction counters.
// One asynchronous read port (fetch index) and one write port (EX index).
// A read and a write to the same index in one cycle return the old value;
// the new value is visible from the next cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset; all counters -> CNT_WNT
//   rd_idx    in   fetch-side counter index
//   rd_taken  out  MSB of the addressed counter (predict taken)
//   wr_en     in   update the counter at wr_idx this edge
//   wr_idx    in   EX-side counter index
//   wr_taken  in   resolved direction used for the update
// -----------------------------------------------------------------------------
module branch_history_table
  import cpu_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(BHT_DEPTH)-1:0] rd_idx,
  output logic                         rd_taken,
  input  logic                         wr_en,
  input  logic [$clog2(BHT_DEPTH)-1:0] wr_idx,
  input  logic                         wr_taken
);

  logic [1:0] counters [BHT_DEPTH];

  // Counter storage: reset to weakly not-taken, otherwise saturating update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        counters[i] <= CNT_WNT;
      end
    end else if (wr_en) begin
      counters[wr_idx] <= cnt_update(counters[wr_idx], wr_taken);
    end
  end

  // Prediction is the counter MSB; read is pre-update (no write bypass)
  assign rd_taken = counters[rd_idx][1];

endmodule

// File: rtl/next_pc_unit.sv
// -----------------------------------------------------------------------------
// next_pc_unit
// Fetch-address generator for the IF stage. Owns the PC register, predicts
// conditional branches at fetch (optional counter table), and resolves
// branches/jumps arriving from EX, redirecting the PC and raising flush on a
// mispredict or jump.
//
// Configuration macro: BRANCH_PREDICT_EN
//   defined   - branch_history_table is instantiated; fetch predicts taken
//               branches and EX compares against ex_pred_taken.
//   undefined - no counter storage, pred_taken is 0, ex_pred_taken ignored,
//               so every taken conditional branch redirects.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset (pc <- RESET_PC)
//   stall           in   hold the fetch PC (flush wins over stall)
//   pc              out  current fetch address (registered)
//   if_br           in   instruction at pc is a conditional branch
//   if_offset       in   sign-extended B-type offset of that instruction
//   pred_taken      out  fetch-time prediction for pc (combinational)
//   ex_valid        in   EX holds a real instruction
//   ex_pc_src       in   EX control-flow kind (see cpu_pkg PCSRC_*)
//   ex_pc           in   PC of the EX instruction
//   ex_offset_addr  in   branch / jal target
//   ex_result       in   ALU result, jalr target
//   ex_zero         in   ALU zero flag
//   ex_less         in   ALU less-than flag
//   ex_pred_taken   in   prediction carried with the EX instruction
//   flush           out  redirect this cycle; IF/ID squash (combinational)
// -----------------------------------------------------------------------------
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BHT_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  input  logic            if_br,
  input  logic [XLEN-1:0] if_offset,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [2:0]      ex_pc_src,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_offset_addr,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_zero,
  input  logic            ex_less,
  input  logic            ex_pred_taken,
  output logic            flush
);

  localparam int unsigned     IDX_W      = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_STEP);
  // jalr targets always have bit 0 cleared
  localparam logic [XLEN-1:0] JALR_MASK  = ~(XLEN'(1'b1));

  logic            ex_cond;      // valid conditional branch in EX
  logic            ex_taken;     // its actual direction
  logic            ex_jal;
  logic            ex_jalr;
  logic            ex_pred_eff;  // prediction EX compares against
  logic            mispredict;
  logic [XLEN-1:0] ex_seq_pc;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_next;

  // ---------------------------------------------------------------------------
  // Prediction storage (optional)
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PREDICT_EN
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             bht_taken;

  // idx(a) = a[log2(BHT_DEPTH)+1:2]; the low two bits are always 0
  assign fetch_idx = pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_idx),
    .rd_taken (bht_taken),
    .wr_en    (ex_cond),
    .wr_idx   (ex_idx),
    .wr_taken (ex_taken)
  );

  // Gated by rst so the output is defined before the counters are loaded
  assign pred_taken  = ~rst & if_br & bht_taken;
  assign ex_pred_eff = ex_pred_taken;
`else
  // Prediction inputs have no consumer without the counter table
  logic unused_predict_inputs;
  assign unused_predict_inputs = ^{if_br, ex_pred_taken};

  assign pred_taken  = 1'b0;
  assign ex_pred_eff = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // EX resolution
  // ---------------------------------------------------------------------------

  // Decode the EX instruction and decide whether fetch must be redirected
  always_comb begin
    ex_cond    = ex_valid & is_cond_branch(ex_pc_src);
    ex_taken   = branch_outcome(ex_pc_src, ex_zero, ex_less);
    ex_jal     = ex_valid & (ex_pc_src == PCSRC_JAL);
    ex_jalr    = ex_valid & (ex_pc_src == PCSRC_JALR);
    mispredict = ex_cond & (ex_taken != ex_pred_eff);
    flush      = mispredict | ex_jal | ex_jalr;
  end

  assign ex_seq_pc = ex_pc + STEP;

  // Redirect address; only meaningful while flush is high
  always_comb begin
    redirect_target = ex_seq_pc;
    if (ex_jalr) begin
      redirect_target = ex_result & JALR_MASK;
    end else if (ex_jal) begin
      redirect_target = ex_offset_addr;
    end else if (ex_taken) begin
      // mispredicted as not-taken
      redirect_target = ex_offset_addr;
    end else begin
      // mispredicted as taken: resume after the branch
      redirect_target = ex_seq_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------------

  // Next-PC priority below rst: redirect, stall hold, predicted target, step
  always_comb begin
    pc_next = pc + STEP;
    if (flush) begin
      pc_next = redirect_target;
    end else if (stall) begin
      pc_next = pc;
    end else if (pred_taken) begin
      pc_next = pc + if_offset;
    end else begin
      pc_next = pc + STEP;
    end
  end

  // Fetch PC; reset discards any redirect pending in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_next_pc_unit
// Directed self-checking bench for next_pc_unit. Expectations that depend on
// BRANCH_PREDICT_EN select between the predicting and non-predicting results.
// -----------------------------------------------------------------------------
module tb_next_pc_unit;

`ifdef BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic        if_br;
  logic [31:0] if_offset;
  logic        pred_taken;
  logic        ex_valid;
  logic [2:0]  ex_pc_src;
  logic [31:0] ex_pc;
  logic [31:0] ex_offset_addr;
  logic [31:0] ex_result;
  logic        ex_zero;
  logic        ex_less;
  logic        ex_pred_taken;
  logic        flush;

  int check_cnt = 0;
  int fail_cnt  = 0;

  next_pc_unit #(
    .XLEN      (32),
    .BHT_DEPTH (64),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc             (pc),
    .if_br          (if_br),
    .if_offset      (if_offset),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_pc_src      (ex_pc_src),
    .ex_pc          (ex_pc),
    .ex_offset_addr (ex_offset_addr),
    .ex_result      (ex_result),
    .ex_zero        (ex_zero),
    .ex_less        (ex_less),
    .ex_pred_taken  (ex_pred_taken),
    .flush          (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid       = 1'b0;
    ex_pc_src      = 3'b000;
    ex_pc          = 32'h0;
    ex_offset_addr = 32'h0;
    ex_result      = 32'h0;
    ex_zero        = 1'b0;
    ex_less        = 1'b0;
    ex_pred_taken  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; if_br = 1'b0; if_offset = 32'h0;
    clear_ex();
    step();
    step();
    check_cnt++; if (pc !== 32'h0) begin fail_cnt++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    check_cnt++; if (flush !== 1'b0) begin fail_cnt++; $display("FAIL reset_flush: got %b want 0", flush); end
    check_cnt++; if (pred_taken !== 1'b0) begin fail_cnt++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
    rst = 1'b0;
    #1;
    check_cnt++; if (pc !== 32'h0) begin fail_cnt++; $display("FAIL release_pc0: got %h want %h", pc, 32'h0); end
    step();
    check_cnt++; if (pc !== 32'h4) begin fail_cnt++; $display("FAIL release_pc4: got %h want %h", pc, 32'h4); end
    step();
    check_cnt++; if (pc !== 32'h8) begin fail_cnt++; $display("FAIL release_pc8: got %h want %h", pc, 32'h8); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    check_cnt++; if (pc !== 32'h8) begin fail_cnt++; $display("FAIL stall_hold1: got %h want %h", pc, 32'h8); end
    step();
    check_cnt++; if (pc !== 32'h8) begin fail_cnt++; $display("FAIL stall_hold2: got %h want %h", pc, 32'h8); end
    stall = 1'b0;
    step();
    check_cnt++; if (pc !== 32'hC) begin fail_cnt++; $display("FAIL stall_resume: got %h want %h", pc, 32'hC); end
  endtask

  task automatic test_beq_mispredict();
    ex_valid = 1'b1; ex_pc_src = 3'b011; ex_zero = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 32'h10; ex_offset_addr = 32'h40;
    #1;
    check_cnt++; if (flush !== 1'b1) begin fail_cnt++; $display("FAIL beq_flush: got %b want 1", flush); end
    step();
    check_cnt++; if (pc !== 32'h40) begin fail_cnt++; $display("FAIL beq_target: got %h want %h", pc, 32'h40); end
    clear_ex();
    #1;
    check_cnt++; if (flush !== 1'b0) begin fail_cnt++; $display("FAIL beq_flush_clear: got %b want 0", flush); end
  endtask

  task automatic test_training();
    // two more taken resolutions at 0x10 with pc held: counter 10 -> 11 -> 11
    stall = 1'b1;
    ex_valid = 1'b1; ex_pc_src = 3'b011; ex_zero = 1'b1; ex_pred_taken = 1'b1;
    ex_pc = 32'h10; ex_offset_addr = 32'h40;
    #1;
    check_cnt++; if (flush !== !PRED) begin fail_cnt++; $display("FAIL train_flush: got %b want %b", flush, !PRED); end
    step();
    check_cnt++; if (pc !== 32'h40) begin fail_cnt++; $display("FAIL train_pc1: got %h want %h", pc, 32'h40); end
    step();
    check_cnt++; if (pc !== 32'h40) begin fail_cnt++; $display("FAIL train_pc2: got %h want %h", pc, 32'h40); end
    // jal back to 0x10, overriding stall
    ex_pc_src = 3'b101; ex_pc = 32'h30; ex_offset_addr = 32'h10; ex_zero = 1'b0; ex_pred_taken = 1'b0;
    #1;
    check_cnt++; if (flush !== 1'b1) begin fail_cnt++; $display("FAIL jal_flush: got %b want 1", flush); end
    step();
    check_cnt++; if (pc !== 32'h10) begin fail_cnt++; $display("FAIL jal_target: got %h want %h", pc, 32'h10); end
    clear_ex();
    stall = 1'b0;
    #1;
    check_cnt++; if (pred_taken !== 1'b0) begin fail_cnt++; $display("FAIL pred_no_br: got %b want 0", pred_taken); end
    if_br = 1'b1; if_offset = 32'hFFFF_FFF0;
    #1;
    check_cnt++; if (pred_taken !== PRED) begin fail_cnt++; $display("FAIL pred_trained: got %b want %b", pred_taken, PRED); end
    step();
    check_cnt++; if (pc !== (PRED ? 32'h0 : 32'h14)) begin fail_cnt++; $display("FAIL pred_next_pc: got %h want %h", pc, (PRED ? 32'h0 : 32'h14)); end
    if_br = 1'b0; if_offset = 32'h0;
  endtask

  task automatic test_bne_not_taken();
    ex_valid = 1'b1; ex_pc_src = 3'b100; ex_zero = 1'b1; ex_pred_taken = 1'b1;
    ex_pc = 32'h20; ex_offset_addr = 32'h80;
    #1;
    check_cnt++; if (flush !== PRED) begin fail_cnt++; $display("FAIL bne_flush: got %b want %b", flush, PRED); end
    step();
    check_cnt++; if (pc !== (PRED ? 32'h24 : 32'h18)) begin fail_cnt++; $display("FAIL bne_next_pc: got %h want %h", pc, (PRED ? 32'h24 : 32'h18)); end
    clear_ex();
  endtask

  task automatic test_counter_decrement();
    // not-taken bne at 0x10 while stalled: counter 11 -> 10
    stall = 1'b1;
    ex_valid = 1'b1; ex_pc_src = 3'b100; ex_zero = 1'b1; ex_pred_taken = 1'b0; ex_pc = 32'h10;
    #1;
    check_cnt++; if (flush !== 1'b0) begin fail_cnt++; $display("FAIL dec_flush: got %b want 0", flush); end
    step();
    check_cnt++; if (pc !== (PRED ? 32'h24 : 32'h18)) begin fail_cnt++; $display("FAIL dec_hold: got %h want %h", pc, (PRED ? 32'h24 : 32'h18)); end
    // jal to 0x10
    stall = 1'b0;
    ex_pc_src = 3'b101; ex_pc = 32'h50; ex_offset_addr = 32'h10; ex_zero = 1'b0;
    step();
    check_cnt++; if (pc !== 32'h10) begin fail_cnt++; $display("FAIL dec_jal: got %h want %h", pc, 32'h10); end
    clear_ex();
    if_br = 1'b1; if_offset = 32'hFFFF_FFF0; stall = 1'b1;
    #1;
    check_cnt++; if (pred_taken !== PRED) begin fail_cnt++; $display("FAIL dec_pred_10: got %b want %b", pred_taken, PRED); end
    // same-index read and update: read still sees the old counter
    ex_valid = 1'b1; ex_pc_src = 3'b100; ex_zero = 1'b1; ex_pred_taken = 1'b0; ex_pc = 32'h10;
    #1;
    check_cnt++; if (pred_taken !== PRED) begin fail_cnt++; $display("FAIL no_bypass: got %b want %b", pred_taken, PRED); end
    step();
    check_cnt++; if (pc !== 32'h10) begin fail_cnt++; $display("FAIL dec_hold2: got %h want %h", pc, 32'h10); end
    clear_ex();
    #1;
    check_cnt++; if (pred_taken !== 1'b0) begin fail_cnt++; $display("FAIL dec_pred_01: got %b want 0", pred_taken); end
    if_br = 1'b0; if_offset = 32'h0; stall = 1'b0;
  endtask

  task automatic test_jalr_stall();
    stall = 1'b1;
    ex_valid = 1'b1; ex_pc_src = 3'b110; ex_result = 32'h101;
    #1;
    check_cnt++; if (flush !== 1'b1) begin fail_cnt++; $display("FAIL jalr_flush: got %b want 1", flush); end
    step();
    check_cnt++; if (pc !== 32'h100) begin fail_cnt++; $display("FAIL jalr_target: got %h want %h", pc, 32'h100); end
    ex_valid = 1'b0;
    #1;
    check_cnt++; if (flush !== 1'b0) begin fail_cnt++; $display("FAIL jalr_bubble_flush: got %b want 0", flush); end
    step();
    check_cnt++; if (pc !== 32'h100) begin fail_cnt++; $display("FAIL jalr_bubble_hold: got %h want %h", pc, 32'h100); end
    stall = 1'b0;
    clear_ex();
  endtask

  task automatic test_blt_bge();
    ex_valid = 1'b1; ex_pc_src = 3'b001; ex_less = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 32'h60; ex_offset_addr = 32'h300;
    #1;
    check_cnt++; if (flush !== 1'b1) begin fail_cnt++; $display("FAIL blt_flush: got %b want 1", flush); end
    step();
    check_cnt++; if (pc !== 32'h300) begin fail_cnt++; $display("FAIL blt_target: got %h want %h", pc, 32'h300); end
    // bge not taken but predicted taken at the top of memory: ex_pc+4 wraps
    ex_pc_src = 3'b010; ex_less = 1'b1; ex_pred_taken = 1'b1;
    ex_pc = 32'hFFFF_FFFC; ex_offset_addr = 32'h500;
    #1;
    check_cnt++; if (flush !== PRED) begin fail_cnt++; $display("FAIL bge_flush: got %b want %b", flush, PRED); end
    step();
    check_cnt++; if (pc !== (PRED ? 32'h0 : 32'h304)) begin fail_cnt++; $display("FAIL bge_wrap: got %h want %h", pc, (PRED ? 32'h0 : 32'h304)); end
    clear_ex();
  endtask

  task automatic test_reserved();
    ex_valid = 1'b1; ex_pc_src = 3'b111; ex_pc = 32'h70; ex_offset_addr = 32'h700;
    ex_zero = 1'b1; ex_less = 1'b1;
    #1;
    check_cnt++; if (flush !== 1'b0) begin fail_cnt++; $display("FAIL rsvd_flush: got %b want 0", flush); end
    step();
    check_cnt++; if (pc !== (PRED ? 32'h4 : 32'h308)) begin fail_cnt++; $display("FAIL rsvd_seq: got %h want %h", pc, (PRED ? 32'h4 : 32'h308)); end
    clear_ex();
  endtask

  task automatic test_reset_redirect();
    ex_valid = 1'b1; ex_pc_src = 3'b101; ex_pc = 32'h80; ex_offset_addr = 32'h200;
    rst = 1'b1;
    #1;
    check_cnt++; if (pred_taken !== 1'b0) begin fail_cnt++; $display("FAIL rst_pred: got %b want 0", pred_taken); end
    step();
    check_cnt++; if (pc !== 32'h0) begin fail_cnt++; $display("FAIL rst_discard: got %h want %h", pc, 32'h0); end
    rst = 1'b0;
    clear_ex();
    #1;
    check_cnt++; if (flush !== 1'b0) begin fail_cnt++; $display("FAIL rst_flush_clear: got %b want 0", flush); end
    step();
    check_cnt++; if (pc !== 32'h4) begin fail_cnt++; $display("FAIL rst_resume: got %h want %h", pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_beq_mispredict();
    test_training();
    test_bne_not_taken();
    test_counter_decrement();
    test_jalr_stall();
    test_blt_bge();
    test_reserved();
    test_reset_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
